// File: rtl/shim_spi_sts_latch.sv
// shim_spi_sts_latch: turns synchronized SPI status levels into sticky latches,
// first-fault capture, a saturating error-event counter and a level interrupt.
module shim_spi_sts_latch #(
  parameter int N_CAT     = 12,
  parameter int N_CH      = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N_CAT*N_CH-1:0]  err_vec,
  input  logic                   spi_off,
  input  logic [N_CAT*N_CH-1:0]  err_mask,
  input  logic                   spi_off_irq_en,
  input  logic                   clr_sticky,
  input  logic [N_CAT*N_CH-1:0]  clr_sel,
  input  logic                   clr_first,
  input  logic                   clr_count,
  input  logic                   clr_spi_off,
  output logic [N_CAT*N_CH-1:0]  sticky,
  output logic                   spi_off_latched,
  output logic                   first_valid,
  output logic [6:0]             first_code,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic                   irq
);
  localparam int N = N_CAT * N_CH;
  logic [N-1:0]         act, rise, act_q, sticky_q, sticky_d;
  logic                 spi_off_q, spl_q, spl_d, fv_q, fv_d, irq_q, irq_d, load;
  logic [6:0]           fc_q, fc_d, low_idx;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    act      = err_vec & err_mask;
    rise     = act & ~act_q;
    low_idx  = '0;
    for (int i = N - 1; i >= 0; i--)
      if (act[i]) low_idx = 7'(i);
    sticky_d = (sticky_q & ~(clr_sticky ? clr_sel : '0)) | act;
    spl_d    = (spl_q & ~clr_spi_off) | (spi_off & ~spi_off_q);
    // a clear strobe re-arms capture in the same cycle it is asserted
    load     = (~fv_q | clr_first) & |act;
    fv_d     = load ? 1'b1 : (clr_first ? 1'b0 : fv_q);
    fc_d     = load ? low_idx : fc_q;
    cnt_d    = clr_count ? '0 : ((|rise && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q);
    irq_d    = |(sticky_d & err_mask) | (spl_d & spi_off_irq_en);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      act_q     <= '0;
      spi_off_q <= 1'b0;
      sticky_q  <= '0;
      spl_q     <= 1'b0;
      fv_q      <= 1'b0;
      fc_q      <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      act_q     <= act;
      spi_off_q <= spi_off;
      sticky_q  <= sticky_d;
      spl_q     <= spl_d;
      fv_q      <= fv_d;
      fc_q      <= fc_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end
  assign sticky          = sticky_q;
  assign spi_off_latched = spl_q;
  assign first_valid     = fv_q;
  assign first_code      = fc_q;
  assign err_count       = cnt_q;
  assign irq             = irq_q;
endmodule

// File: tb/tb_shim_spi_sts_latch.sv
// tb_shim_spi_sts_latch: directed vectors with hand-computed expectations,
// queued by the driver and compared by an independent monitor.
module tb_shim_spi_sts_latch;
  localparam int N = 96;
  localparam logic [N-1:0] ONES = '1;
  logic clk = 1'b0, aresetn = 1'b0;
  logic [N-1:0] err_vec = '0, err_mask = '1, clr_sel = '0;
  logic spi_off = 1'b0, spi_off_irq_en = 1'b0, clr_sticky = 1'b0;
  logic clr_first = 1'b0, clr_count = 1'b0, clr_spi_off = 1'b0;
  logic [N-1:0] sticky;
  logic spi_off_latched, first_valid, irq;
  logic [6:0] first_code;
  logic [1:0] err_count;
  typedef struct {
    logic [N-1:0] st;
    logic spl, fv;
    logic [6:0] fc;
    logic [1:0] cnt;
    logic irq;
    int id;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, n_id = 0;

  shim_spi_sts_latch #(.CNT_WIDTH(2)) dut (
    .aclk(clk), .aresetn(aresetn), .err_vec(err_vec), .spi_off(spi_off),
    .err_mask(err_mask), .spi_off_irq_en(spi_off_irq_en), .clr_sticky(clr_sticky),
    .clr_sel(clr_sel), .clr_first(clr_first), .clr_count(clr_count),
    .clr_spi_off(clr_spi_off), .sticky(sticky), .spi_off_latched(spi_off_latched),
    .first_valid(first_valid), .first_code(first_code), .err_count(err_count), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] b(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input exp_t e, input string name);
    n_chk++;
    if (sticky !== e.st || spi_off_latched !== e.spl || first_valid !== e.fv ||
        first_code !== e.fc || err_count !== e.cnt || irq !== e.irq) begin
      n_fail++;
      $display("FAIL %s #%0d: got st=%h spl=%b fv=%b fc=%0d cnt=%0d irq=%b, want st=%h spl=%b fv=%b fc=%0d cnt=%0d irq=%b",
               name, e.id, sticky, spi_off_latched, first_valid, first_code, err_count, irq,
               e.st, e.spl, e.fv, e.fc, e.cnt, e.irq);
    end
  endtask

  task automatic tick(input logic [N-1:0] st, input logic spl, input logic fv,
                      input logic [6:0] fc, input logic [1:0] cnt, input logic ir);
    exp_t e;
    e.st = st; e.spl = spl; e.fv = fv; e.fc = fc; e.cnt = cnt; e.irq = ir; e.id = n_id++;
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #2;
    if (q.size() > 0) check(q.pop_front(), "step");
  end

  initial begin
    exp_t z;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    tick('0, 0, 0, 0, 0, 0);
    err_vec = b(26);
    tick(b(26), 0, 1, 26, 1, 1);
    err_vec = '0;
    tick(b(26), 0, 1, 26, 1, 1);
    clr_sticky = 1; clr_sel = ONES; clr_first = 1;
    tick('0, 0, 0, 26, 1, 0);
    clr_sticky = 0; clr_sel = '0; clr_first = 0;
    err_vec = b(70) | b(9);
    tick(b(70) | b(9), 0, 1, 9, 2, 1);
    err_vec = b(40);
    tick(b(70) | b(9) | b(40), 0, 1, 9, 3, 1);
    err_vec = b(41); clr_count = 1;
    tick(b(70) | b(9) | b(40) | b(41), 0, 1, 9, 0, 1);
    err_vec = '0; clr_sticky = 1; clr_sel = ONES; clr_first = 1;
    tick('0, 0, 0, 9, 0, 0);
    clr_sticky = 0; clr_sel = '0; clr_first = 0; clr_count = 0;
    // counter saturation with a 2-bit counter
    err_vec = b(1); tick(b(1), 0, 1, 1, 1, 1);
    err_vec = '0;   tick(b(1), 0, 1, 1, 1, 1);
    err_vec = b(1); tick(b(1), 0, 1, 1, 2, 1);
    err_vec = '0;   tick(b(1), 0, 1, 1, 2, 1);
    err_vec = b(1); tick(b(1), 0, 1, 1, 3, 1);
    err_vec = '0;   tick(b(1), 0, 1, 1, 3, 1);
    err_vec = b(1); tick(b(1), 0, 1, 1, 3, 1);
    err_vec = '0;   tick(b(1), 0, 1, 1, 3, 1);
    err_vec = b(1); clr_count = 1;
    tick(b(1), 0, 1, 1, 0, 1);
    err_vec = '0; clr_sticky = 1; clr_sel = ONES; clr_first = 1;
    tick('0, 0, 0, 1, 0, 0);
    clr_sticky = 0; clr_sel = '0; clr_first = 0; clr_count = 0;
    // set wins over clear
    err_vec = b(5);
    tick(b(5), 0, 1, 5, 1, 1);
    clr_sticky = 1; clr_sel = b(5);
    tick(b(5), 0, 1, 5, 1, 1);
    err_vec = '0;
    tick('0, 0, 1, 5, 1, 0);
    clr_sticky = 0; clr_sel = '0;
    // masked bit is inert
    err_mask = ~b(12); err_vec = b(12);
    tick('0, 0, 1, 5, 1, 0);
    err_vec = '0;
    tick('0, 0, 1, 5, 1, 0);
    spi_off = 1;
    tick('0, 1, 1, 5, 1, 0);
    spi_off_irq_en = 1;
    tick('0, 1, 1, 5, 1, 1);
    clr_spi_off = 1;
    tick('0, 0, 1, 5, 1, 0);
    clr_spi_off = 0; spi_off = 0; err_mask = ONES;
    tick('0, 0, 1, 5, 1, 0);
    // re-capture on clr_first with a coincident error
    err_vec = b(33); clr_first = 1;
    tick(b(33), 0, 1, 33, 2, 1);
    err_vec = '0; clr_first = 0;
    tick(b(33), 0, 1, 33, 2, 1);
    #2;
    aresetn = 1'b0;
    #1;
    z.st = '0; z.spl = 0; z.fv = 0; z.fc = 0; z.cnt = 0; z.irq = 0; z.id = n_id++;
    check(z, "async_reset");
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
